nv_ram_rws_param: RTL and testbench

NV_RAM_RWS_PARAM -- requirements
Module: nv_ram_rws_param

---
 rtl/nv_ram_pkg.sv | 8 +
 rtl/nv_ram_byte_merge.sv | 22 ++
 rtl/nv_ram_rws_param.sv | 98 +++++++++
 tb/tb_nv_ram_rws_param.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_pkg.sv
// Shared constants for the nv_ram register-file family: collision modes and byte-lane width.
package nv_ram_pkg;

    localparam int RD_OLD   = 0;
    localparam int WR_FIRST = 1;
    localparam int BYTE_W   = 8;

endpackage

// File: rtl/nv_ram_byte_merge.sv
// Byte-lane merge: takes di bytes where wmask is set, keeps old_word bytes elsewhere.
module nv_ram_byte_merge
    import nv_ram_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [DW-1:0]        old_word,
    input  logic [DW-1:0]        di,
    input  logic [DW/BYTE_W-1:0] wmask,
    output logic [DW-1:0]        merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < DW / BYTE_W; i++) begin
            if (wmask[i]) begin
                merged[i*BYTE_W +: BYTE_W] = di[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/nv_ram_rws_param.sv
// Single-clock 1R1W register-file RAM with byte-masked writes, selectable collision
// behaviour and an optional output pipeline stage.
module nv_ram_rws_param #(
    parameter int DEPTH    = 16,
    parameter int DW       = 64,
    parameter int AW       = 4,
    parameter int OUT_REG  = 0,
    parameter int WR_FIRST = 0
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [AW-1:0]                    ra,
    input  logic                             re,
    output logic [DW-1:0]                    dout,
    output logic                             dout_vld,
    input  logic [AW-1:0]                    wa,
    input  logic                             we,
    input  logic [DW/nv_ram_pkg::BYTE_W-1:0] wmask,
    input  logic [DW-1:0]                    di,
    input  logic [31:0]                      pwrbus_ram_pd
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] wr_word;
    logic [DW-1:0] rd_word;
    logic          wr_en;
    logic          rd_en;
    logic          collide;
    logic [DW-1:0] dout_p0_d, dout_p0_q;
    logic          vld_p0_d,  vld_p0_q;

    // Power bus only matters to physical RAM macros; the behavioural model ignores it.
    logic unused_pwr;
    assign unused_pwr = ^pwrbus_ram_pd;

    // One merge instance serves both the write port and the WR_FIRST forward path,
    // since on a collision mem_q[wa] is the same word the read would have returned.
    nv_ram_byte_merge #(.DW(DW)) u_merge (
        .old_word (mem_q[wa]),
        .di       (di),
        .wmask    (wmask),
        .merged   (wr_word)
    );

    always_comb begin
        wr_en   = rstn && we;
        rd_en   = rstn && re;
        collide = we && (ra == wa);
        case (WR_FIRST)
            nv_ram_pkg::RD_OLD:   rd_word = mem_q[ra];
            nv_ram_pkg::WR_FIRST: rd_word = collide ? wr_word : mem_q[ra];
            default:              rd_word = mem_q[ra];
        endcase
        dout_p0_d = rd_en ? rd_word : dout_p0_q;
        vld_p0_d  = rd_en;
    end

    // Storage: no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wa] <= wr_word;
        end
    end

    // Stage p0: read register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_p0_q <= '0;
            vld_p0_q  <= 1'b0;
        end else begin
            dout_p0_q <= dout_p0_d;
            vld_p0_q  <= vld_p0_d;
        end
    end

    // Stage p1: optional output register, free-running so it mirrors p0 one cycle later.
    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] dout_p1_q;
        logic          vld_p1_q;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                dout_p1_q <= '0;
                vld_p1_q  <= 1'b0;
            end else begin
                dout_p1_q <= dout_p0_q;
                vld_p1_q  <= vld_p0_q;
            end
        end

        assign dout     = dout_p1_q;
        assign dout_vld = vld_p1_q;
    end else begin : g_no_out_reg
        assign dout     = dout_p0_q;
        assign dout_vld = vld_p0_q;
    end

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Scoreboard bench: two RAM instances (OUT_REG=0/WR_FIRST=0 and OUT_REG=1/WR_FIRST=1)
// share stimulus; each read pushes its hand-computed word and arrival cycle per instance.
module tb_nv_ram_rws_param;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  ra, wa;
    logic        re, we;
    logic [7:0]  wmask;
    logic [63:0] di;
    logic [63:0] dout_a, dout_b;
    logic        vld_a, vld_b;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nv_ram_rws_param #(.DEPTH(16), .DW(64), .AW(4), .OUT_REG(0), .WR_FIRST(0)) dut_a (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(32'h0)
    );

    nv_ram_rws_param #(.DEPTH(16), .DW(64), .AW(4), .OUT_REG(1), .WR_FIRST(1)) dut_b (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(32'h0)
    );

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (vld_a) begin
            n_chk++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_vld: dout=%h at cyc %0d, required no pulse", dout_a, cyc);
            end else begin
                e = exp_a.pop_front();
                if (dout_a !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL a_read: got %h at cyc %0d, required %h at cyc %0d",
                             dout_a, cyc, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (vld_b) begin
            n_chk++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_vld: dout=%h at cyc %0d, required no pulse", dout_b, cyc);
            end else begin
                e = exp_b.pop_front();
                if (dout_b !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL b_read: got %h at cyc %0d, required %h at cyc %0d",
                             dout_b, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic drive(input bit r, input logic [3:0] ra_i, input bit w, input logic [3:0] wa_i,
                         input logic [7:0] m, input logic [63:0] d,
                         input logic [63:0] ea, input logic [63:0] eb);
        re = r; ra = ra_i; we = w; wa = wa_i; wmask = m; di = d;
        if (r && rstn) begin
            exp_a.push_back('{ea, cyc + 1});
            exp_b.push_back('{eb, cyc + 2});
        end
        @(posedge clk);
        #1;
        re = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 8'h00, 64'h0, 64'h0, 64'h0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        rstn = 1'b0;
        re = 1'b0; we = 1'b0; ra = '0; wa = '0; wmask = '0; di = '0;

        // Reads and writes presented under reset are discarded.
        drive(1, 9, 1, 9, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, 64'h0, 64'h0);
        drive(1, 3, 0, 0, 8'h00, 64'h0, 64'h0, 64'h0);
        chk("rst_dout_a", dout_a, 64'h0);
        chk("rst_vld_a",  {63'h0, vld_a}, 64'h0);
        chk("rst_dout_b", dout_b, 64'h0);
        chk("rst_vld_b",  {63'h0, vld_b}, 64'h0);
        rstn = 1'b1;
        idle(1);

        // Full-word write then read.
        drive(0, 0, 1, 3, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0);
        drive(1, 3, 0, 0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        idle(2);

        // Byte mask: low four bytes cleared.
        drive(0, 0, 1, 5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        drive(0, 0, 1, 5, 8'h0F, 64'h0, 0, 0);
        drive(1, 5, 0, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000);
        idle(2);

        // Full-mask collision, then confirm the write landed.
        drive(0, 0, 1, 7, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0);
        drive(1, 7, 1, 7, 8'hFF, 64'h5555_5555_5555_5555,
              64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
        drive(1, 7, 0, 0, 8'h00, 64'h0, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555);
        idle(2);

        // Partial-mask collision: forwarded word merges new upper bytes with old lower bytes.
        drive(0, 0, 1, 6, 8'hFF, 64'h1111_1111_1111_1111, 0, 0);
        drive(1, 6, 1, 6, 8'hF0, 64'h2222_2222_2222_2222,
              64'h1111_1111_1111_1111, 64'h2222_2222_1111_1111);
        idle(2);

        // Back-to-back reads of 0,1,2.
        drive(0, 0, 1, 0, 8'hFF, 64'h10, 0, 0);
        drive(0, 0, 1, 1, 8'hFF, 64'h20, 0, 0);
        drive(0, 0, 1, 2, 8'hFF, 64'h30, 0, 0);
        drive(1, 0, 0, 0, 8'h00, 64'h0, 64'h10, 64'h10);
        drive(1, 1, 0, 0, 8'h00, 64'h0, 64'h20, 64'h20);
        drive(1, 2, 0, 0, 8'h00, 64'h0, 64'h30, 64'h30);
        idle(3);

        // Hold: dout keeps the last read even after the word is rewritten.
        drive(0, 0, 1, 4, 8'hFF, 64'h11, 0, 0);
        drive(1, 4, 0, 0, 8'h00, 64'h0, 64'h11, 64'h11);
        idle(3);
        drive(0, 0, 1, 4, 8'hFF, 64'h22, 0, 0);
        idle(2);
        chk("hold_dout_a", dout_a, 64'h11);
        chk("hold_vld_a",  {63'h0, vld_a}, 64'h0);
        chk("hold_dout_b", dout_b, 64'h11);
        chk("hold_vld_b",  {63'h0, vld_b}, 64'h0);

        // Reset one edge after a read: dut_a already showed it, dut_b loses it in p1.
        drive(0, 0, 1, 9, 8'hFF, 64'h9999_9999_9999_9999, 0, 0);
        drive(1, 9, 0, 0, 8'h00, 64'h0, 64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999);
        void'(exp_b.pop_back());
        rstn = 1'b0;
        drive(1, 9, 1, 9, 8'hFF, 64'h0, 0, 0);
        drive(0, 0, 0, 0, 8'h00, 64'h0, 0, 0);
        chk("midrst_dout_a", dout_a, 64'h0);
        chk("midrst_dout_b", dout_b, 64'h0);
        chk("midrst_vld_b",  {63'h0, vld_b}, 64'h0);
        rstn = 1'b1;
        drive(1, 9, 0, 0, 8'h00, 64'h0, 64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999);
        idle(4);

        n_chk++;
        if (exp_a.size() != 0) begin
            n_fail++;
            $display("FAIL a_drain: %0d reads outstanding, required 0", exp_a.size());
        end
        n_chk++;
        if (exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL b_drain: %0d reads outstanding, required 0", exp_b.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
